arb_rr8_ctrl: RTL and testbench
===============================

# arb_rr8_ctrl

Round-robin arbiter sharing a single 8-way resource, such as a decoded select bus, among eight requesters. It accepts a request vector, issues exactly one registered one-hot grant plus its 3-bit index, holds the grant until release, and can force a release when a hold timeout expires. The one-hot grant comes from an enabled 3-to-8 decoder stage driven by the registered index. The block sits between requesting agents and the shared datapath's decoder select lines.

## Interface
- `HOLD_MAX`, default 16: maximum cycles a grant may be held; legal range 2..255.
- `CW`, default 8: width of the hold counter; must satisfy HOLD_MAX ≤ 2^CW − 1.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset; one clock; reset is asynchronous and active-low.
- `req`  in  8  request vector; bit i high means requester i wants the resource.
- `done`  in  1  release strobe from the current owner; sampled only in BUSY.
- `grant`  out  8  one-hot grant; all zero when `grant_valid`=0.
- `grant_idx`  out  3  binary index of the owner; holds its last value when not valid.
- `grant_valid`  out  1  high while a grant is held.
- `timeout`  out  1  one-cycle pulse on a forced release.

## Operation
- **Reset values:**
  - `grant`=8'h00, `grant_idx`=3'd0, `grant_valid`=0, `timeout`=0.
  - Internal pointer `last`=3'd7, hold counter=0, state=IDLE.
- **States:** IDLE, BUSY.
- **IDLE:**
  - If `req`≠0, select the first set bit scanning from `last`+1 upward, wrapping mod 8.
  - Register its index into `grant_idx` and `last`, set `grant_valid`=1, clear the counter, and go to BUSY.
  - If `req`=0, stay in IDLE with outputs invalid.
- **BUSY:**
  - Counter increments each cycle.
  - Release condition: `done`=1, or `req[grant_idx]`=0 (requester withdrew), or counter = HOLD_MAX−1.
  - On release: go to IDLE, `grant_valid`=0, and `grant`=0 on the next edge.
- **Timeout:** pulses for exactly the release cycle's next edge, only when the release cause is the counter alone. If `done` or a withdrawal coincides with the limit, the release is normal and `timeout` stays 0.
- **Pointer:** `last` updates only on a new grant, never on release. A requester that just released therefore ranks last in the next arbitration.
- **Grant decode:** `grant` = decode(`grant_idx`) gated by `grant_valid`. It is always one-hot or zero, never multi-hot.
- **Input handling:** `req` changes on non-owner bits during BUSY are ignored. `done` is ignored in IDLE.
- **Reset mid-grant:** outputs drop asynchronously to their reset values and `last` returns to 7.

## Timing
- **Request to grant:** `req` seen in IDLE at edge N gives `grant_valid`=1 after edge N, i.e. 1-cycle latency.
- **Release to re-grant:** release sampled at edge M gives `grant_valid`=0 after M. The next grant appears after M+1 at the earliest, leaving one mandatory idle cycle between owners.
- **Maximum hold:** HOLD_MAX cycles of `grant_valid`=1 per grant.
- **Starvation bound:** a continuously requesting agent waits at most 7 × (HOLD_MAX+1) cycles.
- **Output timing:** all outputs are registered except `grant`, which is a decode of registers. There is no combinational path from inputs to outputs.

## Structure
- Shared package holds:
  - state encoding constants `ST_IDLE`=1'b0, `ST_BUSY`=1'b1;
  - `NREQ`=8;
  - `IDXW`=3.
- Sub-module `onehot_dec3to8`: 3-bit input, enable, 8-bit one-hot output. It produces `grant` from `grant_idx` and `grant_valid`.
- Top level contains the FSM, the rotate-priority encoder (combinational, wrap-around search), `last`, and the hold counter.

## Test plan
- **First grant after reset:** reset, then `req`=8'b1000_0001 → `grant_idx`=0, `grant`=8'h01 after 1 cycle.
- **Rotation:** `req`=8'hFF held with `done` pulsed each BUSY cycle → `grant_idx` sequence 0,1,2,…,7,0, with `grant_valid` low for one cycle between each grant.
- **Wrap-around priority:** `last`=6, `req`=8'b0100_0001 → grant to 0, not 6.
- **Forced release:** HOLD_MAX=16, owner never asserts `done` → `grant_valid` high exactly 16 cycles, then `timeout`=1 for one cycle and `grant`=0.
- **Coincident release:** `done`=1 on the timeout cycle → release with `timeout`=0.
- **Withdrawal and reset:**
  - Owner drops its `req` mid-grant → release next edge.
  - `rst_n` asserted mid-BUSY → `grant`=0 immediately; the next arbitration with `req`=8'hFF grants index 0.

Source files
------------

// File: rtl/arb_rr8_ctrl_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb_rr8_ctrl_pkg : shared types, sizes and rotate-priority pick function
// Rev 1.0
// ----------------------------------------------------------------------------
package arb_rr8_ctrl_pkg;

  localparam int NREQ = 8;
  localparam int IDXW = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  // Scans last+1, last+2, ... wrapping mod 8; last itself is checked last so
  // the previous owner has the lowest priority.
  function automatic logic [IDXW-1:0] rr_pick(input logic [NREQ-1:0] req,
                                              input logic [IDXW-1:0] last);
    logic [IDXW-1:0] pick;
    logic [IDXW-1:0] cand;
    logic            found;
    pick  = last;
    found = 1'b0;
    for (int i = 1; i <= NREQ; i++) begin
      cand = last + IDXW'(i);
      if (!found && req[cand]) begin
        pick  = cand;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/arb_rr8_ctrl_onehot_dec3to8.sv
`default_nettype none
// ----------------------------------------------------------------------------
// onehot_dec3to8 : enabled 3-to-8 one-hot decoder driving the grant lines
// Rev 1.0
// ----------------------------------------------------------------------------
module onehot_dec3to8
  import arb_rr8_ctrl_pkg::*;
(
  input  logic [IDXW-1:0] idx_i,
  input  logic            en_i,
  output logic [NREQ-1:0] onehot_o
);

  for (genvar i = 0; i < NREQ; i++) begin : g_dec
    assign onehot_o[i] = en_i && (idx_i == IDXW'(i));
  end

endmodule
`default_nettype wire

// File: rtl/arb_rr8_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// arb_rr8_ctrl : 8-way round-robin arbiter with registered grant and hold timeout
// Rev 1.0
// ----------------------------------------------------------------------------
module arb_rr8_ctrl
  import arb_rr8_ctrl_pkg::*;
#(
  parameter int HOLD_MAX = 16,
  parameter int CW       = 8
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [NREQ-1:0] req_i,
  input  logic            done_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDXW-1:0] grant_idx_o,
  output logic            grant_valid_o,
  output logic            timeout_o
);

  localparam logic [CW-1:0] HOLD_LIM = CW'(HOLD_MAX - 1);

  state_t          state_q, state_d;
  logic [IDXW-1:0] idx_q, idx_d;
  logic [IDXW-1:0] last_q, last_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            valid_q, valid_d;
  logic            timeout_q, timeout_d;

  logic [IDXW-1:0] pick_idx;
  logic            hold_hit;
  logic            owner_quit;

  assign pick_idx   = rr_pick(req_i, last_q);
  assign hold_hit   = (cnt_q == HOLD_LIM);
  assign owner_quit = done_i || !req_i[idx_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      last_q    <= IDXW'(NREQ - 1);
      cnt_q     <= '0;
      valid_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      valid_q   <= valid_d;
      timeout_q <= timeout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    valid_d   = valid_q;
    timeout_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (|req_i) begin
          idx_d   = pick_idx;
          last_d  = pick_idx;
          cnt_d   = '0;
          valid_d = 1'b1;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        cnt_d = cnt_q + CW'(1);
        if (owner_quit || hold_hit) begin
          valid_d   = 1'b0;
          state_d   = ST_IDLE;
          // A forced release is flagged only when the counter is the sole cause.
          timeout_d = hold_hit && !owner_quit;
        end
      end
      default: begin
        state_d = ST_IDLE;
        valid_d = 1'b0;
      end
    endcase
  end

  onehot_dec3to8 u_dec (
    .idx_i    (idx_q),
    .en_i     (valid_q),
    .onehot_o (grant_o)
  );

  assign grant_idx_o   = idx_q;
  assign grant_valid_o = valid_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_arb_rr8_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_arb_rr8_ctrl : scoreboard bench for the round-robin arbiter
// Rev 1.0
// ----------------------------------------------------------------------------
module tb_arb_rr8_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] req_i = 8'h00;
  logic       done_i = 1'b0;
  logic [7:0] grant_o;
  logic [2:0] grant_idx_o;
  logic       grant_valid_o;
  logic       timeout_o;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [2:0]  idx;
    logic [31:0] len;
    logic        to;
  } exp_t;

  exp_t sb[$];

  arb_rr8_ctrl #(.HOLD_MAX(16), .CW(8)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .req_i         (req_i),
    .done_i        (done_i),
    .grant_o       (grant_o),
    .grant_idx_o   (grant_idx_o),
    .grant_valid_o (grant_valid_o),
    .timeout_o     (timeout_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push(input logic [2:0] idx, input int len, input logic to);
    exp_t e;
    e.idx = idx;
    e.len = len;
    e.to  = to;
    sb.push_back(e);
  endtask

  task automatic wait_grant(input string name, output int cyc);
    cyc = 0;
    do begin
      @(posedge clk);
      #1;
      cyc++;
    end while (!grant_valid_o && cyc < 64);
    if (!grant_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: no grant within 64 cycles", name);
    end
  endtask

  task automatic wait_release(input string name);
    int n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
    end while (grant_valid_o && n < 64);
    if (grant_valid_o) begin
      checks++;
      errors++;
      $display("FAIL %s: grant not released within 64 cycles", name);
    end
  endtask

  // Monitor: tracks each grant and checks it against the scoreboard on release.
  initial begin : monitor
    logic       prev_v;
    logic [2:0] cur_idx;
    int         len;
    exp_t       e;
    prev_v  = 1'b0;
    cur_idx = 3'd0;
    len     = 0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        prev_v = 1'b0;
        len    = 0;
      end else begin
        if (grant_valid_o) begin
          check("grant_onehot", grant_o, 8'h01 << grant_idx_o);
          check("timeout_while_held", timeout_o, 0);
          if (!prev_v) begin
            cur_idx = grant_idx_o;
            len     = 1;
          end else begin
            len++;
          end
        end else begin
          check("grant_zero_idle", grant_o, 0);
          if (prev_v) begin
            if (sb.size() == 0) begin
              checks++;
              errors++;
              $display("FAIL unexpected_grant: idx %0d had no expectation", cur_idx);
            end else begin
              e = sb.pop_front();
              check("grant_idx", cur_idx, e.idx);
              check("hold_len", len, e.len);
              check("timeout_on_release", timeout_o, e.to);
            end
          end
        end
        prev_v = grant_valid_o;
      end
    end
  end

  initial begin : stimulus
    int c;
    repeat (2) @(posedge clk);
    #1;
    check("rst_grant", grant_o, 8'h00);
    check("rst_idx", grant_idx_o, 3'd0);
    check("rst_valid", grant_valid_o, 1'b0);
    check("rst_timeout", timeout_o, 1'b0);
    rst_n = 1'b1;

    // First grant after reset: last=7 so index 0 wins over 7.
    push(3'd0, 1, 1'b0);
    req_i = 8'h81;
    wait_grant("first_grant", c);
    check("first_grant_latency", c, 1);
    done_i = 1'b1;
    wait_release("first_release");

    // Rotation with done held high: 1..7 then wrap to 0.
    for (int k = 1; k <= 8; k++) push(3'(k % 8), 1, 1'b0);
    req_i = 8'hFF;
    for (int k = 1; k <= 8; k++) begin
      wait_grant("rotation", c);
      if (k > 1) check("rotation_idle_gap", c, 2);
    end
    req_i = 8'h00;
    wait_release("rotation_release");
    done_i = 1'b0;

    // Move last to 6, then 8'b0100_0001 must grant 0.
    push(3'd6, 1, 1'b0);
    req_i = 8'h40;
    wait_grant("set_last6", c);
    done_i = 1'b1;
    wait_release("set_last6_release");
    done_i = 1'b0;
    push(3'd0, 16, 1'b1);
    req_i = 8'h41;
    wait_grant("wrap_grant", c);
    check("wrap_latency", c, 1);

    // Owner 0 never finishes: forced release after 16 cycles.
    wait_release("forced_release");

    // Owner 6 asserts done exactly on the limit cycle: normal release.
    push(3'd6, 16, 1'b0);
    wait_grant("coincident_grant", c);
    repeat (15) @(posedge clk);
    #1;
    done_i = 1'b1;
    wait_release("coincident_release");
    done_i = 1'b0;

    // Withdrawal; non-owner bit changes are ignored meanwhile.
    push(3'd0, 4, 1'b0);
    push(3'd6, 1, 1'b0);
    wait_grant("withdraw_grant", c);
    req_i = 8'hC1;
    repeat (3) @(posedge clk);
    #1;
    req_i = 8'h40;
    wait_release("withdraw_release");
    wait_grant("after_withdraw", c);
    done_i = 1'b1;
    wait_release("after_withdraw_release");
    done_i = 1'b0;

    // Reset mid-grant.
    req_i = 8'hFF;
    wait_grant("pre_reset_grant", c);
    check("pre_reset_owner", grant_idx_o, 3'd7);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_rst_grant", grant_o, 8'h00);
    check("async_rst_valid", grant_valid_o, 1'b0);
    check("async_rst_idx", grant_idx_o, 3'd0);
    check("async_rst_timeout", timeout_o, 1'b0);
    @(posedge clk);
    #1;
    push(3'd0, 1, 1'b0);
    rst_n = 1'b1;
    wait_grant("post_reset_grant", c);
    check("post_reset_latency", c, 1);
    check("post_reset_idx", grant_idx_o, 3'd0);
    done_i = 1'b1;
    wait_release("post_reset_release");
    done_i = 1'b0;
    req_i  = 8'h00;

    repeat (3) @(posedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
